// File: rtl/draw_pkg.sv
// Shared types and constants for the screen painters on the 160x120 playfield.
package draw_pkg;

    localparam int unsigned SCREEN_W = 160;
    localparam int unsigned SCREEN_H = 120;
    localparam int unsigned XW       = 8;
    localparam int unsigned YW       = 7;
    localparam int unsigned CW       = 3;

    localparam logic [CW-1:0] BLACK = 3'b000;
    localparam logic [CW-1:0] RED   = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP,
        S_BOTTOM,
        S_LEFT,
        S_RIGHT,
        S_MARK,
        S_DONE
    } state_t;

    // Rectangle handed to the scanner on a reload.
    typedef struct packed {
        logic [XW-1:0] x;
        logic [YW-1:0] y;
        logic [XW-1:0] w;
        logic [YW-1:0] h;
    } region_t;

endpackage

// File: rtl/rect_scan.sv
// Generic row-major 2D scanner: walks a loaded rectangle one pixel per advance.
module rect_scan
    import draw_pkg::*;
(
    input  logic          clock,
    input  logic          resetn,
    input  logic          load_i,
    input  logic [XW-1:0] base_x_i,
    input  logic [YW-1:0] base_y_i,
    input  logic [XW-1:0] width_i,
    input  logic [YW-1:0] height_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, x_d, x_base_q, x_base_d, x_end_q, x_end_d;
    logic [YW-1:0] y_q, y_d, y_end_q, y_end_d;
    logic          last_q, last_d;

    // Next position: reload wins over stepping; x runs fastest, wrapping to the base column.
    always_comb begin
        x_d      = x_q;
        y_d      = y_q;
        x_base_d = x_base_q;
        x_end_d  = x_end_q;
        y_end_d  = y_end_q;
        if (load_i) begin
            x_d      = base_x_i;
            y_d      = base_y_i;
            x_base_d = base_x_i;
            x_end_d  = base_x_i + width_i - XW'(1);
            y_end_d  = base_y_i + height_i - YW'(1);
        end else if (advance_i) begin
            if (x_q == x_end_q) begin
                x_d = x_base_q;
                y_d = y_q + YW'(1);
            end else begin
                x_d = x_q + XW'(1);
            end
        end
        last_d = (x_d == x_end_d) && (y_d == y_end_d);
    end

    // Position registers; last is registered alongside so it describes the pixel on x_o/y_o.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            x_q      <= '0;
            y_q      <= '0;
            x_base_q <= '0;
            x_end_q  <= '0;
            y_end_q  <= '0;
            last_q   <= 1'b0;
        end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            x_base_q <= x_base_d;
            x_end_q  <= x_end_d;
            y_end_q  <= y_end_d;
            last_q   <= last_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign last_o = last_q;

endmodule

// File: rtl/frame_drawer.sv
// Border-and-marker painter: outline of THICK pixels then an optional filled marker.
module frame_drawer
    import draw_pkg::*;
#(
    parameter int unsigned   X0          = 25,
    parameter int unsigned   Y0          = 20,
    parameter int unsigned   X1          = 135,
    parameter int unsigned   Y1          = 104,
    parameter int unsigned   THICK       = 1,
    parameter logic [CW-1:0] COLOUR      = 3'b100,
    parameter int unsigned   MARK_X      = 133,
    parameter int unsigned   MARK_Y      = 21,
    parameter int unsigned   MARK_W      = 2,
    parameter int unsigned   MARK_H      = 2,
    parameter logic [CW-1:0] MARK_COLOUR = 3'b100
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          start,
    input  logic          erase,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic [CW-1:0] colour,
    output logic          plot,
    output logic          busy,
    output logic          done
);

    localparam bit MARK_EN = (MARK_W != 0) && (MARK_H != 0);

    localparam bit PARAMS_OK =
        (X0 < X1) && (X1 < SCREEN_W) && (Y0 < Y1) && (Y1 < SCREEN_H) &&
        (THICK >= 1) && (THICK <= 8) &&
        (2 * THICK <= X1 - X0 + 1) && (2 * THICK <= Y1 - Y0 + 1) &&
        (!MARK_EN || ((MARK_X + MARK_W <= SCREEN_W) && (MARK_Y + MARK_H <= SCREEN_H)));

    state_t        state_q, state_d;
    logic          erase_q, erase_d;
    logic [CW-1:0] colour_q, colour_d;
    logic          plot_q, plot_d, busy_q, busy_d, done_q, done_d;
    logic          load, advance, scan_last;
    region_t       region;

    // Rectangle scanned in each state; IDLE/DONE park the scanner at (0,0).
    function automatic region_t region_of(input state_t s);
        region_t r;
        case (s)
            S_TOP:    r = '{x: XW'(X0), y: YW'(Y0), w: XW'(X1 - X0 + 1), h: YW'(THICK)};
            S_BOTTOM: r = '{x: XW'(X0), y: YW'(Y1 - THICK + 1), w: XW'(X1 - X0 + 1), h: YW'(THICK)};
            S_LEFT:   r = '{x: XW'(X0), y: YW'(Y0), w: XW'(THICK), h: YW'(Y1 - Y0 + 1)};
            S_RIGHT:  r = '{x: XW'(X1 - THICK + 1), y: YW'(Y0), w: XW'(THICK), h: YW'(Y1 - Y0 + 1)};
            S_MARK:   r = '{x: XW'(MARK_X), y: YW'(MARK_Y), w: XW'(MARK_W), h: YW'(MARK_H)};
            default:  r = '0;
        endcase
        return r;
    endfunction

    // Next state, scanner control and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        erase_d = erase_q;
        advance = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_TOP;
                    erase_d = erase;
                end
            end
            S_TOP:    if (scan_last) state_d = S_BOTTOM; else advance = 1'b1;
            S_BOTTOM: if (scan_last) state_d = S_LEFT;   else advance = 1'b1;
            S_LEFT:   if (scan_last) state_d = S_RIGHT;  else advance = 1'b1;
            S_RIGHT:  if (scan_last) state_d = MARK_EN ? S_MARK : S_DONE; else advance = 1'b1;
            S_MARK:   if (scan_last) state_d = S_DONE;   else advance = 1'b1;
            S_DONE: begin
                // The edge leaving DONE doubles as the IDLE sample, so a held start runs back-to-back.
                if (start) begin
                    state_d = S_TOP;
                    erase_d = erase;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        load   = (state_d != state_q);
        region = region_of(state_d);

        case (state_d)
            S_TOP, S_BOTTOM, S_LEFT, S_RIGHT: colour_d = COLOUR;
            S_MARK:                           colour_d = MARK_COLOUR;
            default:                          colour_d = BLACK;
        endcase
        if (erase_d) colour_d = BLACK;

        plot_d = (state_d != S_IDLE) && (state_d != S_DONE);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State, erase latch and output registers.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q  <= S_IDLE;
            erase_q  <= 1'b0;
            colour_q <= BLACK;
            plot_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            erase_q  <= erase_d;
            colour_q <= colour_d;
            plot_q   <= plot_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Single scanner, reloaded at every region boundary.
    rect_scan u_scan (
        .clock     (clock),
        .resetn    (resetn),
        .load_i    (load),
        .base_x_i  (region.x),
        .base_y_i  (region.y),
        .width_i   (region.w),
        .height_i  (region.h),
        .advance_i (advance),
        .x_o       (x),
        .y_o       (y),
        .last_o    (scan_last)
    );

    // Out-of-range geometry is a configuration error, flagged in simulation.
    always_ff @(posedge clock) begin : p_param_check
        assert (PARAMS_OK) else $error("frame_drawer: illegal parameter set");
    end

    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_frame_drawer.sv
// Scoreboard bench: a rectangle-list model predicts every output cycle of two frame_drawer instances.
module tb_frame_drawer;

    typedef struct packed {
        logic       plot;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       busy;
        logic       done;
    } rec_t;

    logic       clock;
    logic       resetn;
    logic       start0, start1, erase;
    logic [7:0] d0_x, d1_x;
    logic [6:0] d0_y, d1_y;
    logic [2:0] d0_c, d1_c;
    logic       d0_plot, d1_plot, d0_busy, d1_busy, d0_done, d1_done;

    rec_t exp0[$];
    rec_t exp1[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;
    bit   mon_en     = 1'b0;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    frame_drawer u_dut0 (
        .clock  (clock),
        .resetn (resetn),
        .start  (start0),
        .erase  (erase),
        .x      (d0_x),
        .y      (d0_y),
        .colour (d0_c),
        .plot   (d0_plot),
        .busy   (d0_busy),
        .done   (d0_done)
    );

    frame_drawer #(
        .X0(10), .Y0(10), .X1(19), .Y1(19), .THICK(2), .COLOUR(3'b011),
        .MARK_X(0), .MARK_Y(0), .MARK_W(0), .MARK_H(2), .MARK_COLOUR(3'b111)
    ) u_dut1 (
        .clock  (clock),
        .resetn (resetn),
        .start  (start1),
        .erase  (erase),
        .x      (d1_x),
        .y      (d1_y),
        .colour (d1_c),
        .plot   (d1_plot),
        .busy   (d1_busy),
        .done   (d1_done)
    );

    // Reference model: one record per pixel of a filled rectangle.
    task automatic push_rect(input int which, input int bx, input int by,
                             input int w, input int h, input logic [2:0] c);
        rec_t r;
        for (int yy = by; yy < by + h; yy++) begin
            for (int xx = bx; xx < bx + w; xx++) begin
                r = '{plot: 1'b1, x: 8'(xx), y: 7'(yy), c: c, busy: 1'b1, done: 1'b0};
                if (which == 0) exp0.push_back(r); else exp1.push_back(r);
            end
        end
    endtask

    // Whole frame: four border strips, optional marker, then the DONE cycle.
    task automatic push_frame(input int which, input bit er);
        int fx0, fy0, fx1, fy1, t, mx, my, mw, mh;
        logic [2:0] col, mcol;
        rec_t r;
        if (which == 0) begin
            fx0 = 25; fy0 = 20; fx1 = 135; fy1 = 104; t = 1;
            mx = 133; my = 21; mw = 2; mh = 2; col = 3'b100; mcol = 3'b100;
        end else begin
            fx0 = 10; fy0 = 10; fx1 = 19; fy1 = 19; t = 2;
            mx = 0; my = 0; mw = 0; mh = 2; col = 3'b011; mcol = 3'b111;
        end
        if (er) begin
            col  = 3'b000;
            mcol = 3'b000;
        end
        push_rect(which, fx0, fy0, fx1 - fx0 + 1, t, col);
        push_rect(which, fx0, fy1 - t + 1, fx1 - fx0 + 1, t, col);
        push_rect(which, fx0, fy0, t, fy1 - fy0 + 1, col);
        push_rect(which, fx1 - t + 1, fy0, t, fy1 - fy0 + 1, col);
        if (mw > 0 && mh > 0) push_rect(which, mx, my, mw, mh, mcol);
        r = '{plot: 1'b0, x: 8'd0, y: 7'd0, c: 3'b000, busy: 1'b1, done: 1'b1};
        if (which == 0) exp0.push_back(r); else exp1.push_back(r);
    endtask

    // Colour is only defined while plotting or straight after reset.
    task automatic check_rec(input string name, input rec_t a, input rec_t e);
        rec_t am;
        am = a;
        if (!e.plot && resetn) am.c = e.c;
        vectors++;
        if (am !== e) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got plot=%0b x=%0d y=%0d c=%03b busy=%0b done=%0b, expected plot=%0b x=%0d y=%0d c=%03b busy=%0b done=%0b",
                     name, cyc, a.plot, a.x, a.y, a.c, a.busy, a.done,
                     e.plot, e.x, e.y, e.c, e.busy, e.done);
        end
    endtask

    // Monitor: every cycle pops the predicted record, or expects idle outputs when none is queued.
    always @(negedge clock) begin : monitor
        rec_t a, e;
        cyc++;
        if (mon_en) begin
            a = '{plot: d0_plot, x: d0_x, y: d0_y, c: d0_c, busy: d0_busy, done: d0_done};
            e = '0;
            if (exp0.size() > 0) e = exp0.pop_front();
            check_rec("inst0", a, e);
            a = '{plot: d1_plot, x: d1_x, y: d1_y, c: d1_c, busy: d1_busy, done: d1_done};
            e = '0;
            if (exp1.size() > 0) e = exp1.pop_front();
            check_rec("inst1", a, e);
        end
    end

    // One-cycle start pulse; returns during the first pixel cycle.
    task automatic start_frames(input bit s0, input bit s1, input bit er);
        @(negedge clock); #1;
        erase  = er;
        start0 = s0;
        start1 = s1;
        if (s0) push_frame(0, er);
        if (s1) push_frame(1, er);
        @(negedge clock); #1;
        start0 = 1'b0;
        start1 = 1'b0;
        erase  = 1'($urandom_range(0, 1));
    endtask

    initial begin : stimulus
        bit er;
        int p;
        resetn = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        erase  = 1'b0;
        repeat (2) @(posedge clock);
        mon_en = 1'b1;
        repeat (2) @(negedge clock);
        #1 resetn = 1'b1;

        // Default geometry and the THICK=2 no-marker geometry, painted then erased.
        start_frames(1'b1, 1'b1, 1'b0);
        repeat (400) @(negedge clock);
        start_frames(1'b1, 1'b1, 1'b1);
        repeat (400) @(negedge clock);

        // Extra start pulse at pixel 50 must be ignored by both.
        start_frames(1'b1, 1'b1, 1'($urandom_range(0, 1)));
        repeat (49) @(negedge clock);
        #1 begin start0 = 1'b1; start1 = 1'b1; end
        @(negedge clock); #1 begin start0 = 1'b0; start1 = 1'b0; end
        repeat (400) @(negedge clock);

        // Randomised frames with a stray start somewhere mid-frame.
        for (int i = 0; i < 5; i++) begin
            er = 1'($urandom_range(0, 1));
            p  = int'($urandom_range(2, 390));
            start_frames(1'b1, 1'($urandom_range(0, 1)), er);
            repeat (p - 1) @(negedge clock);
            #1 start0 = 1'b1;
            @(negedge clock); #1 start0 = 1'b0;
            repeat (400 - p + int'($urandom_range(0, 5))) @(negedge clock);
        end

        // Reset during pixel 200 aborts the frame with no done pulse.
        start_frames(1'b1, 1'b0, 1'b0);
        repeat (199) @(negedge clock);
        #1 begin
            resetn = 1'b0;
            exp0.delete();
            exp1.delete();
        end
        @(negedge clock); #1 resetn = 1'b1;
        start_frames(1'b1, 1'b1, 1'b0);
        repeat (400) @(negedge clock);

        // Start held high: three back-to-back frames on inst0, four on inst1.
        er = 1'($urandom_range(0, 1));
        @(negedge clock); #1 begin
            erase  = er;
            start0 = 1'b1;
            start1 = 1'b1;
            for (int f = 0; f < 3; f++) push_frame(0, er);
            for (int f = 0; f < 4; f++) push_frame(1, er);
        end
        repeat (253) @(negedge clock);
        #1 start1 = 1'b0;
        repeat (551) @(negedge clock);
        #1 start0 = 1'b0;
        repeat (420) @(negedge clock);

        vectors++;
        if (exp0.size() != 0 || exp1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d/%0d records still pending, expected 0/0",
                     exp0.size(), exp1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
